// File: rtl/job_rr_scheduler_pkg.sv
// Shared constants for the round-robin job scheduler: FSM encodings and counter width.
package job_rr_scheduler_pkg;

  localparam int unsigned TO_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RUN   = 2'd3;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker: first set req bit at or after ptr, wrapping.
module rr_priority_pick
  import job_rr_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IDX_W-1:0] pick_idx,
  output logic             any
);

  logic             found;
  logic [IDX_W-1:0] j_idx;

  assign any = |req;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    j_idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j_idx = IDX_W'((32'(ptr) + 32'(k)) % N_REQ);
      if (!found && req[j_idx]) begin
        found       = 1'b1;
        pick[j_idx] = 1'b1;
        pick_idx    = j_idx;
      end
    end
  end

endmodule

// File: rtl/job_rr_scheduler.sv
// Shares one single-job worker among N_REQ requesters: round-robin pick, start pulse,
// busy tracking, and done / start-timeout reporting back to the owner.
module job_rr_scheduler
  import job_rr_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned IDX_W   = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             busy,
  output logic             start,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] owner,
  output logic             active,
  output logic [N_REQ-1:0] done,
  output logic             timeout_err
);

  logic [1:0]       state, state_d;
  logic [IDX_W-1:0] ptr, ptr_d;
  logic [TO_W-1:0]  cnt, cnt_d;
  logic [N_REQ-1:0] gnt_d, done_d;
  logic [IDX_W-1:0] owner_d;
  logic             start_d, active_d, to_d;

  logic [N_REQ-1:0] pick;
  logic [IDX_W-1:0] pick_idx;
  logic             any;

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req      (req),
    .ptr      (ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (any)
  );

  // State, pointer, counter and all outputs are registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      cnt         <= '0;
      gnt         <= '0;
      owner       <= '0;
      start       <= 1'b0;
      active      <= 1'b0;
      done        <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      cnt         <= cnt_d;
      gnt         <= gnt_d;
      owner       <= owner_d;
      start       <= start_d;
      active      <= active_d;
      done        <= done_d;
      timeout_err <= to_d;
    end
  end

  // Next state and next output values; pulses default low every cycle.
  always_comb begin
    state_d  = state;
    ptr_d    = ptr;
    cnt_d    = cnt;
    gnt_d    = gnt;
    owner_d  = owner;
    active_d = active;
    start_d  = 1'b0;
    done_d   = '0;
    to_d     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any) begin
          state_d  = ST_ISSUE;
          gnt_d    = pick;
          owner_d  = pick_idx;
          start_d  = 1'b1;
          active_d = 1'b1;
          ptr_d    = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
        end
      end
      ST_ISSUE: begin
        // busy is deliberately ignored here so a stale high level cannot skip WAIT
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        if (busy) begin
          state_d = ST_RUN;
        end else if (cnt == TO_W'(TIMEOUT - 1)) begin
          state_d  = ST_IDLE;
          to_d     = 1'b1;
          gnt_d    = '0;
          active_d = 1'b0;
        end else begin
          cnt_d = cnt + TO_W'(1);
        end
      end
      ST_RUN: begin
        if (!busy) begin
          state_d  = ST_IDLE;
          done_d   = gnt;
          gnt_d    = '0;
          active_d = 1'b0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        gnt_d    = '0;
        active_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_job_rr_scheduler.sv
// Scoreboard bench for job_rr_scheduler: expected start/done/timeout events are queued
// with their cycle numbers as stimulus is applied and matched as the DUT emits them.
module tb_job_rr_scheduler;

  localparam int N   = 4;
  localparam int TMO = 15;
  localparam int K_START = 0;
  localparam int K_DONE  = 1;
  localparam int K_TO    = 2;

  typedef struct {
    int kind;
    int idx;
    int cyc;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         busy;
  logic         start;
  logic [N-1:0] gnt;
  logic [1:0]   owner;
  logic         active;
  logic [N-1:0] done;
  logic         timeout_err;

  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  ev_t q[$];

  int  wk_d, wk_l, wk_s, cur_owner;
  bit  wk_en, wk_armed, stale;

  job_rr_scheduler #(
    .N_REQ   (N),
    .TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .busy        (busy),
    .start       (start),
    .gnt         (gnt),
    .owner       (owner),
    .active      (active),
    .done        (done),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic take(input int kind, input string tag, output ev_t e, output bit ok);
    ok = 1'b0;
    e  = '{-1, -1, -1};
    if (q.size() == 0) begin
      check_val({"unexpected_", tag}, 1, 0);
    end else begin
      e  = q.pop_front();
      ok = 1'b1;
      check_val({tag, "_kind"}, kind, e.kind);
      check_val({tag, "_cycle"}, cyc, e.cyc);
    end
  endtask

  task automatic monitor();
    ev_t e;
    bit  ok;
    if (start) begin
      take(K_START, "start", e, ok);
      if (ok) begin
        check_val("start_owner", owner, e.idx);
        check_val("start_gnt", gnt, 1 << e.idx);
        check_val("start_active", active, 1);
      end
      cur_owner = owner;
    end
    if (done != 0) begin
      take(K_DONE, "done", e, ok);
      if (ok) check_val("done_vec", done, 1 << e.idx);
      check_val("done_gnt_low", gnt, 0);
      check_val("done_active_low", active, 0);
      check_val("done_no_timeout", timeout_err, 0);
      req &= ~done;
    end
    if (timeout_err) begin
      take(K_TO, "timeout", e, ok);
      check_val("timeout_gnt_low", gnt, 0);
      check_val("timeout_no_done", done, 0);
      check_val("timeout_active_low", active, 0);
      req &= ~(4'(1) << cur_owner);
    end
    if (active && !start) begin
      check_val("gnt_hold", gnt, 1 << cur_owner);
      check_val("owner_hold", owner, cur_owner);
    end
  endtask

  // Behavioural worker: busy rises wk_d cycles after the start cycle and lasts wk_l cycles.
  task automatic worker();
    if (rst) begin
      wk_armed = 1'b0;
      busy     = 1'b0;
    end else begin
      if (start) begin
        wk_s     = cyc;
        wk_armed = wk_en;
      end
      busy = wk_armed && (cyc >= wk_s + wk_d) && (cyc < wk_s + wk_d + wk_l);
      if (start && stale) busy = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    monitor();
    worker();
  endtask

  task automatic push_job(input int idx, input int s, output int done_cyc);
    done_cyc = s + wk_d + wk_l + 1;
    q.push_back('{K_START, idx, s});
    q.push_back('{K_DONE, idx, done_cyc});
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) step();
    check_val("drain_empty", q.size(), 0);
    q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_start"}, start, 0);
    check_val({tag, "_gnt"}, gnt, 0);
    check_val({tag, "_owner"}, owner, 0);
    check_val({tag, "_active"}, active, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_timeout"}, timeout_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, s;
    rst = 1'b1; req = '0; busy = 1'b0;
    wk_en = 1'b1; wk_armed = 1'b0; stale = 1'b0;
    wk_d = 1; wk_l = 1; wk_s = 0; cur_owner = 0;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // single requester, busy from the cycle after start for 5 cycles
    wk_d = 1; wk_l = 5;
    req = 4'b0100;
    push_job(2, cyc + 1, d);
    drain(40);

    // pointer now 3: 3 wins first, then wraps to 0
    wk_d = 2; wk_l = 3;
    req = 4'b1001;
    push_job(3, cyc + 1, d);
    push_job(0, d + 1, d);
    drain(60);

    // contention from ptr=1, back-to-back jobs
    wk_d = 2; wk_l = 2;
    req = 4'b1111;
    s = cyc + 1;
    push_job(1, s, d);
    push_job(2, d + 1, d);
    push_job(3, d + 1, d);
    push_job(0, d + 1, d);
    drain(100);

    // worker never responds: timeout TMO+1 cycles after start
    wk_en = 1'b0;
    req = 4'b0010;
    s = cyc + 1;
    q.push_back('{K_START, 1, s});
    q.push_back('{K_TO, 1, s + TMO + 1});
    drain(60);
    wk_en = 1'b1;
    wk_d = 1; wk_l = 2;
    req = 4'b0100;
    push_job(2, cyc + 1, d);
    drain(40);

    // stale busy during the issue cycle must not skip the wait phase
    stale = 1'b1;
    wk_d = 3; wk_l = 2;
    req = 4'b1000;
    push_job(3, cyc + 1, d);
    drain(40);
    stale = 1'b0;

    // requester drops req while its job runs: done still delivered
    wk_d = 1; wk_l = 4;
    req = 4'b0001;
    push_job(0, cyc + 1, d);
    repeat (3) step();
    req = '0;
    drain(40);

    // reset during RUN: no done, outputs cleared, pointer back to 0
    wk_d = 1; wk_l = 6;
    req = 4'b0100;
    q.push_back('{K_START, 2, cyc + 1});
    repeat (3) step();
    rst = 1'b1;
    req = '0;
    step();
    check_all_zero("midreset");
    check_val("midreset_queue", q.size(), 0);
    rst = 1'b0;
    repeat (6) step();
    wk_d = 1; wk_l = 1;
    req = 4'b1001;
    push_job(0, cyc + 1, d);
    push_job(3, d + 1, d);
    drain(40);

    repeat (5) step();
    check_val("final_queue", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
